// File: rtl/ucu_pkg.sv
// Shared encodings and the micro-word layout for the multicycle ARM-subset micro-sequencer.
package ucu_pkg;

   localparam int UPC_W = 4;

   typedef enum logic [UPC_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } upc_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'd0;
   localparam logic [1:0] RES_DATA      = 2'd1;
   localparam logic [1:0] RES_ALURESULT = 2'd2;

   localparam logic [1:0] SRCB_RM     = 2'd0;
   localparam logic [1:0] SRCB_EXTIMM = 2'd1;
   localparam logic [1:0] SRCB_FOUR   = 2'd2;

   // Enables here are candidates; the top gates them with halt, mem_ready, cond_ex and no_reg_w.
   typedef struct packed {
      logic       valid;
      logic       memReq;
      logic       adrSrc;
      logic       irWrite;
      logic       nextPc;
      logic       branch;
      logic       memW;
      logic       regW;
      logic       regWChk;
      logic [1:0] resultSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       aluOp;
   } micro_word_t;

endpackage

// File: rtl/micro_rom.sv
// Combinational micro-ROM: maps the micro-PC to its control word; unused codes read as all zero.
module micro_rom
   import ucu_pkg::*;
(
   input  upc_e        upc,
   output micro_word_t word
);

   always_comb begin
      word = '0;
      case (upc)
         FETCH: begin
            word.valid     = 1'b1;
            word.memReq    = 1'b1;
            word.irWrite   = 1'b1;
            word.nextPc    = 1'b1;
            word.resultSrc = RES_ALURESULT;
            word.aluSrcA   = 1'b1;
            word.aluSrcB   = SRCB_FOUR;
         end
         DECODE: begin
            // PC+8 is formed here so Rn==R15 reads the architectural value
            word.valid     = 1'b1;
            word.resultSrc = RES_ALURESULT;
            word.aluSrcA   = 1'b1;
            word.aluSrcB   = SRCB_FOUR;
         end
         MEMADR: begin
            word.valid   = 1'b1;
            word.aluSrcB = SRCB_EXTIMM;
         end
         MEMRD: begin
            word.valid  = 1'b1;
            word.memReq = 1'b1;
            word.adrSrc = 1'b1;
         end
         MEMWB: begin
            word.valid     = 1'b1;
            word.regW      = 1'b1;
            word.resultSrc = RES_DATA;
         end
         MEMWR: begin
            word.valid  = 1'b1;
            word.memReq = 1'b1;
            word.adrSrc = 1'b1;
            word.memW   = 1'b1;
         end
         EXECR: begin
            word.valid   = 1'b1;
            word.aluSrcB = SRCB_RM;
            word.aluOp   = 1'b1;
         end
         EXECI: begin
            word.valid   = 1'b1;
            word.aluSrcB = SRCB_EXTIMM;
            word.aluOp   = 1'b1;
         end
         ALUWB: begin
            word.valid     = 1'b1;
            word.regW      = 1'b1;
            word.regWChk   = 1'b1;
            word.resultSrc = RES_ALUOUT;
         end
         BRANCH: begin
            word.valid     = 1'b1;
            word.branch    = 1'b1;
            word.resultSrc = RES_ALURESULT;
            word.aluSrcB   = SRCB_EXTIMM;
         end
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer for the multicycle datapath: dispatch, enable gating and retired-instruction count.
module micro_sequencer
   import ucu_pkg::*;
#(
   parameter int UPC_W     = ucu_pkg::UPC_W,
   parameter int RET_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           op,
   input  logic [5:0]           funct,
   input  logic                 cond_ex,
   input  logic                 no_reg_w,
   input  logic                 mem_ready,
   input  logic                 halt,
   output logic                 mem_req,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 next_pc,
   output logic                 branch,
   output logic                 mem_w,
   output logic                 reg_w,
   output logic [1:0]           result_src,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 alu_op,
   output logic                 illegal_op,
   output logic [RET_CNT_W-1:0] retired
);

   logic [UPC_W-1:0] upcQ;
   upc_e             upcCur;
   upc_e             upcNext;
   micro_word_t      word;
   logic             retire;
   logic             decodeIllegal;
   logic             active;
   logic             unusedFunct;

   assign upcCur      = upc_e'(upcQ);
   assign unusedFunct = ^funct[4:1];

   micro_rom uRom (
      .upc  (upcCur),
      .word (word)
   );

   always_comb begin
      upcNext       = upcCur;
      retire        = 1'b0;
      decodeIllegal = 1'b0;
      case (upcCur)
         FETCH:  if (!halt && mem_ready) upcNext = DECODE;
         DECODE: begin
            case (op)
               OP_MEM:  upcNext = MEMADR;
               OP_DP:   upcNext = funct[5] ? EXECI : EXECR;
               OP_BR:   upcNext = BRANCH;
               default: begin
                  upcNext       = FETCH;
                  decodeIllegal = 1'b1;
               end
            endcase
         end
         MEMADR: upcNext = funct[0] ? MEMRD : MEMWR;
         MEMRD:  if (mem_ready) upcNext = MEMWB;
         MEMWR: begin
            if (mem_ready) begin
               upcNext = FETCH;
               retire  = 1'b1;
            end
         end
         EXECR, EXECI: upcNext = ALUWB;
         MEMWB, ALUWB, BRANCH: begin
            upcNext = FETCH;
            retire  = 1'b1;
         end
         default: upcNext = FETCH;
      endcase
   end

   // A halted FETCH and reset both force every control line low.
   assign active = reset_n && !(upcCur == FETCH && halt);

   assign mem_req    = active & word.memReq;
   assign adr_src    = active & word.adrSrc;
   assign ir_write   = active & word.irWrite & mem_ready;
   assign next_pc    = active & word.nextPc & mem_ready;
   assign branch     = active & word.branch & cond_ex;
   assign mem_w      = active & word.memW & cond_ex;
   assign reg_w      = active & word.regW & cond_ex & ~(word.regWChk & no_reg_w);
   assign result_src = active ? word.resultSrc : 2'd0;
   assign alu_src_a  = active & word.aluSrcA;
   assign alu_src_b  = active ? word.aluSrcB : 2'd0;
   assign alu_op     = active & word.aluOp;
   assign illegal_op = reset_n & (decodeIllegal | ~word.valid);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         upcQ    <= UPC_W'(FETCH);
         retired <= '0;
      end else begin
         upcQ <= UPC_W'(upcNext);
         if (retire) retired <= retired + RET_CNT_W'(1);
      end
   end

endmodule
